// File: rtl/wb_cfg_master.sv
// Wishbone classic single-cycle initiator driven by a valid/ready command stream.
// Optional bus timeout enabled by defining WB_CFG_TIMEOUT_EN.
module wb_cfg_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned WRITE_RSP      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [DATA_W/8-1:0] cmd_sel,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [DATA_W-1:0]   wbm_dat_i,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   cmd_fire;
  logic   write_silent;

  assign cmd_fire     = cmd_valid && cmd_ready;
  assign write_silent = wbm_we_o && (WRITE_RSP == 0);

  if (TIMEOUT_CYCLES == 0 || (DATA_W % 8) != 0) begin : g_param_check
    $error("wb_cfg_master: TIMEOUT_CYCLES must be >= 1 and DATA_W a multiple of 8");
  end

`ifdef WB_CFG_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      busy      <= 1'b0;
`ifdef WB_CFG_TIMEOUT_EN
      rsp_err   <= 1'b0;
      tmo_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            state     <= BUS;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= cmd_we;
            wbm_sel_o <= cmd_sel;
            wbm_adr_o <= cmd_addr;
            wbm_dat_o <= cmd_data;
`ifdef WB_CFG_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        BUS: begin
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_data  <= wbm_we_o ? '0 : wbm_dat_i;
`ifdef WB_CFG_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            if (write_silent) begin
              state     <= IDLE;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end
`ifdef WB_CFG_TIMEOUT_EN
          end else if (tmo_hit) begin
            // Timeouts always report, even for writes that would otherwise be silent.
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cfg_master.sv
// Bench for wb_cfg_master: vector table plus hand-written corner sequences,
// responses checked against a scoreboard queue filled when commands are driven.
module tb_wb_cfg_master;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = DATA_W / 8;
  localparam int unsigned TMO    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_we;
  logic [SEL_W-1:0]  cmd_sel;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_data;
  logic              cyc, stb, we;
  logic [SEL_W-1:0]  sel;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat_o, dat_i;
  logic              ack, busy;

  wb_cfg_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WRITE_RSP(1), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_ack_i(ack), .wbm_dat_i(dat_i),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    int unsigned       ack_dly;
    int unsigned       stall;
    logic [DATA_W-1:0] exp_data;
    logic              exp_err;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_t;

  rsp_t        exp_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned beats   = 0;
  int unsigned exp_beats = 0;

  always @(posedge clk) if (!rst && rsp_valid && rsp_ready) beats++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input vec_t v);
    cmd_valid = 1'b1;
    cmd_we    = v.we;
    cmd_sel   = v.sel;
    cmd_addr  = v.addr;
    cmd_data  = v.wdata;
  endtask

  task automatic expect_rsp(input vec_t v);
    rsp_t r;
    r.data = v.exp_data;
    r.err  = v.exp_err;
    exp_q.push_back(r);
    exp_beats++;
  endtask

  task automatic send_cmd(input vec_t v);
    int unsigned n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    drive_cmd(v);
    tick();
    cmd_valid = 1'b0;
    chk("bus_start_cyc_stb", {62'd0, cyc, stb}, 64'd3);
    chk("bus_we", {63'd0, we}, {63'd0, v.we});
    chk("bus_sel", {60'd0, sel}, {60'd0, v.sel});
    chk("bus_adr", {32'd0, adr}, {32'd0, v.addr});
    chk("bus_dat", {32'd0, dat_o}, {32'd0, v.wdata});
    chk("bus_busy_noready", {62'd0, busy, cmd_ready}, 64'd2);
  endtask

  task automatic bus_phase(input vec_t v);
    for (int i = 0; i < int'(v.ack_dly); i++) begin
      tick();
      chk("bus_hold", {29'd0, cyc, stb, adr}, {29'd0, 2'b11, v.addr});
    end
    ack   = 1'b1;
    dat_i = v.rdata;
    tick();
    ack   = 1'b0;
    dat_i = 32'hBAD0_0BAD;
    chk("bus_end_cyc_stb", {62'd0, cyc, stb}, 64'd0);
  endtask

  task automatic rsp_phase(input vec_t v, input bit hold_next, input bit ack_in_resp,
                           input vec_t nv);
    logic [DATA_W-1:0] d;
    rsp_t              e;
    chk("rsp_valid_up", {63'd0, rsp_valid}, 64'd1);
    d = rsp_data;
    if (hold_next) drive_cmd(nv);
    for (int i = 0; i < int'(v.stall); i++) begin
      if (ack_in_resp && i == 0) ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("rsp_stall_hold", {30'd0, rsp_valid, busy, rsp_data}, {30'd0, 2'b11, d});
      chk("rsp_stall_idle_bus", {62'd0, cmd_ready, cyc}, 64'd0);
    end
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk("rsp_data", {32'd0, rsp_data}, {32'd0, e.data});
      chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_done", {61'd0, rsp_valid, busy, cmd_ready}, 64'd1);
  endtask

  task automatic do_txn(input vec_t v);
    expect_rsp(v);
    send_cmd(v);
    bus_phase(v);
    rsp_phase(v, 1'b0, 1'b0, v);
  endtask

  function automatic vec_t mk(input logic w, input logic [SEL_W-1:0] s, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd,
                              input int unsigned dly, input int unsigned st);
    vec_t v;
    v.we = w; v.sel = s; v.addr = a; v.wdata = wd; v.rdata = rd;
    v.ack_dly = dly; v.stall = st;
    v.exp_data = w ? '0 : rd;
    v.exp_err  = 1'b0;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vec_t v, v2;

    vecs[0] = mk(1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_0001, 32'h1111_2222, 1, 0);
    vecs[1] = mk(1'b0, 4'hF, 32'h3000_0010, 32'h0000_0000, 32'h1234_5678, 0, 0);
    vecs[2] = mk(1'b0, 4'hF, 32'h3000_0020, 32'h5555_5555, 32'hDEAD_BEEF, 3, 2);
    vecs[3] = mk(1'b1, 4'h3, 32'h3000_0008, 32'h0000_BEEF, 32'hFFFF_FFFF, 0, 1);
    vecs[4] = mk(1'b0, 4'h1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_00FF, 2, 0);
    vecs[5] = mk(1'b1, 4'hC, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 5, 0);

    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = '0; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b0; ack = 1'b0; dat_i = '0;
    repeat (3) tick();
    chk("reset_ctrl", {59'd0, cmd_ready, rsp_valid, rsp_err, busy, cyc}, 64'd0);
    chk("reset_bus", {57'd0, stb, we, sel, 1'b0}, 64'd0);
    chk("reset_adr_dat", {adr, dat_o}, 64'd0);
    chk("reset_rsp_data", {32'd0, rsp_data}, 64'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", {63'd0, cmd_ready}, 64'd1);

    for (int i = 0; i < 6; i++) do_txn(vecs[i]);

    // Stalled response with a second command queued behind it.
    v  = mk(1'b0, 4'hF, 32'h3000_0030, 32'h0, 32'hCAFE_F00D, 0, 5);
    v2 = mk(1'b1, 4'h6, 32'h3000_0040, 32'h0BAD_CAFE, 32'h0, 1, 0);
    expect_rsp(v);
    send_cmd(v);
    bus_phase(v);
    rsp_phase(v, 1'b1, 1'b0, v2);
    expect_rsp(v2);
    send_cmd(v2);
    bus_phase(v2);
    rsp_phase(v2, 1'b0, 1'b0, v2);

    // Stray acks in IDLE and RESP.
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("idle_ack_ignored", {60'd0, busy, cyc, rsp_valid, cmd_ready}, 64'd1);
    v = mk(1'b0, 4'hF, 32'h3000_0050, 32'h0, 32'h0F0F_0F0F, 0, 2);
    expect_rsp(v);
    send_cmd(v);
    bus_phase(v);
    rsp_phase(v, 1'b0, 1'b1, v);

    // Reset while the cycle is open.
    v = mk(1'b1, 4'hF, 32'h3000_0060, 32'h7777_8888, 32'h0, 3, 0);
    send_cmd(v);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_async_drop", {59'd0, cyc, stb, busy, rsp_valid, cmd_ready}, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    chk("after_rst_quiet", {61'd0, cyc, rsp_valid, cmd_ready}, 64'd1);
    do_txn(vecs[1]);

`ifdef WB_CFG_TIMEOUT_EN
    v = mk(1'b1, 4'hF, 32'h3000_0070, 32'h1234_0000, 32'h0, 0, 0);
    v.exp_data = '0;
    v.exp_err  = 1'b1;
    expect_rsp(v);
    send_cmd(v);
    for (int i = 0; i < int'(TMO) - 1; i++) begin
      tick();
      chk("tmo_cyc_hold", {63'd0, cyc}, 64'd1);
    end
    tick();
    chk("tmo_cyc_drop", {62'd0, cyc, stb}, 64'd0);
    rsp_phase(v, 1'b0, 1'b0, v);
    v = mk(1'b0, 4'hF, 32'h3000_0074, 32'h0, 32'h8765_4321, TMO - 1, 0);
    do_txn(v);
`endif

    tick();
    chk("rsp_beat_count", {32'd0, beats}, {32'd0, exp_beats});
    chk("scoreboard_drained", {32'd0, exp_q.size()}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
